// File: rtl/adpcm_b_pkg.sv
// Shared definitions for the ADPCM-B sample-memory bus requester:
// state encoding, default phase timings and address field positions.
package adpcm_b_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR_LO   = 3'd1,
        ADDR_HI   = 3'd2,
        DATA_WAIT = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    localparam int T_LO_DEF   = 4;
    localparam int T_HI_DEF   = 6;
    localparam int T_WAIT_DEF = 8;

    // LSB positions of each bus field within the 24-bit byte address
    localparam int LO_PAD = 0;
    localparam int LO_PA  = 8;
    localparam int HI_PAD = 12;
    localparam int HI_PA  = 20;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adpcm_b_phase_timer.sv
// Reloadable down-counter; tc is high while the count sits at zero.
module adpcm_b_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/adpcm_b_requester.sv
// Chip-side ADPCM-B memory bus requester: multiplexes a 24-bit address onto
// PAD/PA around the PMPX strobe, then releases PAD and samples the data byte.
module adpcm_b_requester
    import adpcm_b_pkg::*;
#(
    parameter int T_LO   = T_LO_DEF,
    parameter int T_HI   = T_HI_DEF,
    parameter int T_WAIT = T_WAIT_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [23:0]      req_addr,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             pmpx,
    output logic [7:0]       pad_out,
    output logic             pad_oe,
    output logic [3:0]       pa_out,
    input  logic [7:0]       pad_in,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] busy_cycles,
    input  logic             count_clear
);

    localparam int T_MAX = max3(T_LO, T_HI, T_WAIT);
    localparam int TMR_W = $clog2(T_MAX + 1);

    generate
        if (T_LO < 1 || T_HI < 1 || T_WAIT < 1) begin : g_bad_timing
            $error("adpcm_b_requester: T_LO, T_HI and T_WAIT must all be >= 1");
        end
    endgenerate

    state_t           state;
    logic [7:0]       hi_pad_q;
    logic [3:0]       hi_pa_q;
    logic             accept;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_tc;

    assign accept = req_valid && req_ready;

    // The timer is reloaded on the same edge that enters a timed phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: if (accept) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(T_LO - 1);
            end
            ADDR_LO: if (tmr_tc) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(T_HI - 1);
            end
            ADDR_HI: if (tmr_tc) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(T_WAIT - 1);
            end
            default: ;
        endcase
    end

    adpcm_b_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            pmpx      <= 1'b0;
            pad_oe    <= 1'b0;
            pad_out   <= 8'h00;
            pa_out    <= 4'h0;
            hi_pad_q  <= 8'h00;
            hi_pa_q   <= 4'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state     <= ADDR_LO;
                    req_ready <= 1'b0;
                    pmpx      <= 1'b1;
                    pad_oe    <= 1'b1;
                    pad_out   <= req_addr[LO_PAD +: 8];
                    pa_out    <= req_addr[LO_PA +: 4];
                    hi_pad_q  <= req_addr[HI_PAD +: 8];
                    hi_pa_q   <= req_addr[HI_PA +: 4];
                end
                ADDR_LO: if (tmr_tc) begin
                    state   <= ADDR_HI;
                    pmpx    <= 1'b0;
                    pad_out <= hi_pad_q;
                    pa_out  <= hi_pa_q;
                end
                ADDR_HI: if (tmr_tc) begin
                    state   <= DATA_WAIT;
                    pad_oe  <= 1'b0;
                    pad_out <= 8'h00;
                end
                DATA_WAIT: if (tmr_tc) begin
                    state     <= RESPOND;
                    rsp_data  <= pad_in;
                    rsp_valid <= 1'b1;
                end
                RESPOND: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    pmpx      <= 1'b0;
                    pad_oe    <= 1'b0;
                    pad_out   <= 8'h00;
                end
            endcase
        end
    end

    // Clear wins over increment so a clear on an accept edge still reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_count   <= '0;
            busy_cycles <= '0;
        end else if (count_clear) begin
            req_count   <= '0;
            busy_cycles <= '0;
        end else begin
            if (accept)
                req_count <= req_count + 1'b1;
            if (state != IDLE && busy_cycles != '1)
                busy_cycles <= busy_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_adpcm_b_requester.sv
// Directed bench for adpcm_b_requester: default-timing instance plus a
// minimum-timing instance, with a response scoreboard.
module tb_adpcm_b_requester;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        req_valid = 1'b0;
    logic [23:0] req_addr = '0;
    logic        req_ready, rsp_valid, pmpx, pad_oe;
    logic [7:0]  rsp_data, pad_out;
    logic [3:0]  pa_out;
    logic [7:0]  pad_in = '0;
    logic [15:0] req_count, busy_cycles;
    logic        count_clear = 1'b0;

    logic        req_valid_b = 1'b0;
    logic [23:0] req_addr_b = '0;
    logic        req_ready_b, rsp_valid_b, pmpx_b, pad_oe_b;
    logic [7:0]  rsp_data_b, pad_out_b;
    logic [3:0]  pa_out_b;
    logic [7:0]  pad_in_b = '0;
    logic [15:0] req_count_b, busy_cycles_b;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    adpcm_b_requester dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .pmpx(pmpx), .pad_out(pad_out), .pad_oe(pad_oe), .pa_out(pa_out),
        .pad_in(pad_in), .req_count(req_count), .busy_cycles(busy_cycles),
        .count_clear(count_clear)
    );

    adpcm_b_requester #(.T_LO(1), .T_HI(1), .T_WAIT(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_b), .req_addr(req_addr_b), .req_ready(req_ready_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
        .pmpx(pmpx_b), .pad_out(pad_out_b), .pad_oe(pad_oe_b), .pa_out(pa_out_b),
        .pad_in(pad_in_b), .req_count(req_count_b), .busy_cycles(busy_cycles_b),
        .count_clear(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic on_rsp();
        if (rsp_valid) begin
            if (sb.size() == 0) check("sb_unexpected_rsp", 32'd1, 32'd0);
            else check("rsp_data", {24'h0, rsp_data}, {24'h0, sb.pop_front()});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int edges[$];
        int high_cnt, rsp_cyc, pulses;
        logic prev;

        // reset state
        tick();
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_pmpx",      {31'h0, pmpx},      32'd0);
        check("rst_pad_oe",    {31'h0, pad_oe},    32'd0);
        check("rst_rsp_data",  {24'h0, rsp_data},  32'd0);
        check("rst_req_count", {16'h0, req_count}, 32'd0);
        reset_n = 1'b1;
        tick();

        // single request, full bus timeline
        req_addr = 24'hA5C37E;
        req_valid = 1'b1;
        sb.push_back(8'h96);
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("t1_pmpx_c%0d", c), {31'h0, pmpx}, {31'h0, (c <= 4)});
            check($sformatf("t1_pad_oe_c%0d", c), {31'h0, pad_oe}, {31'h0, (c <= 10)});
            check($sformatf("t1_pad_out_c%0d", c), {24'h0, pad_out},
                  (c <= 4) ? 32'h7E : (c <= 10) ? 32'h5C : 32'h00);
            check($sformatf("t1_pa_out_c%0d", c), {28'h0, pa_out}, (c <= 4) ? 32'h3 : 32'hA);
            check($sformatf("t1_rsp_valid_c%0d", c), {31'h0, rsp_valid}, {31'h0, (c == 19)});
            check($sformatf("t1_req_ready_c%0d", c), {31'h0, req_ready}, {31'h0, (c >= 20)});
            on_rsp();
            pad_in = (c == 18) ? 8'h96 : 8'h11;
            tick();
        end
        check("t1_rsp_data_held", {24'h0, rsp_data}, 32'h96);

        // three back-to-back requests with req_valid held high
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        check("t2_cleared", {16'h0, req_count}, 32'd0);
        pad_in = 8'h42;
        req_addr = 24'h0F1234;
        repeat (3) sb.push_back(8'h42);
        req_valid = 1'b1;
        prev = pmpx;
        tick();
        for (int c = 1; c <= 60; c++) begin
            if (pmpx && !prev) edges.push_back(c);
            prev = pmpx;
            on_rsp();
            if (c == 41) req_valid = 1'b0;
            tick();
        end
        check("t2_edge_count", edges.size(), 32'd3);
        if (edges.size() == 3) begin
            check("t2_edge0", edges[0], 32'd1);
            check("t2_edge1", edges[1], 32'd21);
            check("t2_edge2", edges[2], 32'd41);
        end
        check("t2_req_count", {16'h0, req_count}, 32'd3);
        check("t2_busy_cycles", {16'h0, busy_cycles}, 32'd57);

        // req_valid pulsed during ADDR_HI is ignored
        edges.delete();
        sb.push_back(8'h42);
        req_valid = 1'b1;
        prev = pmpx;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (pmpx && !prev) edges.push_back(c);
            prev = pmpx;
            if (c == 6) begin
                check("t3_ready_in_hi", {31'h0, req_ready}, 32'd0);
                req_valid = 1'b1;
            end
            if (c == 7) req_valid = 1'b0;
            on_rsp();
            tick();
        end
        check("t3_edge_count", edges.size(), 32'd1);
        check("t3_req_count", {16'h0, req_count}, 32'd4);

        // count_clear on the accept edge wins over the increment
        sb.push_back(8'h42);
        req_valid = 1'b1;
        count_clear = 1'b1;
        tick();
        req_valid = 1'b0;
        count_clear = 1'b0;
        check("t6_req_count", {16'h0, req_count}, 32'd0);
        check("t6_pmpx", {31'h0, pmpx}, 32'd1);
        for (int c = 1; c <= 24; c++) begin
            on_rsp();
            tick();
        end

        // asynchronous reset in DATA_WAIT aborts the transfer
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (12) tick();
        check("t4_pre_ready", {31'h0, req_ready}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t4_pmpx", {31'h0, pmpx}, 32'd0);
        check("t4_pad_oe", {31'h0, pad_oe}, 32'd0);
        check("t4_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("t4_req_ready", {31'h0, req_ready}, 32'd1);
        check("t4_req_count", {16'h0, req_count}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid) pulses++;
            tick();
        end
        check("t4_no_rsp_after_abort", pulses, 32'd0);
        check("t4_ready_after", {31'h0, req_ready}, 32'd1);

        // minimum timing instance
        req_addr_b = 24'h123456;
        pad_in_b = 8'h3C;
        req_valid_b = 1'b1;
        tick();
        req_valid_b = 1'b0;
        high_cnt = 0;
        rsp_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) check("t5_pad_out_lo", {24'h0, pad_out_b}, 32'h56);
            if (pmpx_b) high_cnt++;
            if (rsp_valid_b) begin
                rsp_cyc = c;
                check("t5_rsp_data", {24'h0, rsp_data_b}, 32'h3C);
            end
            tick();
        end
        check("t5_pmpx_high_cycles", high_cnt, 32'd1);
        check("t5_rsp_cycle", rsp_cyc, 32'd4);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
